uart_rx_ctrl: RTL and testbench

UART receive-path controller: start-bit detection FSM, edge/bit counters and 8-bit LSB-first deserializer.
- Consumes the majority-voted sampled_bit from the data sampler.
- Drives the enables of the start, parity and stop checkers and samples their error flags.
- Presents P_DATA with a one-cycle data_valid strobe to the RX-side synchronizer.
- Sits between the oversampling data sampler and the parity/start/stop checkers in the UART RX.

---
 rtl/uart_rx_pkg.sv | 31 +++
 rtl/uart_rx_ctrl_if.sv | 31 +++
 rtl/uart_rx_edge_bit_cnt.sv | 55 +++++
 rtl/uart_rx_ctrl.sv | 126 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive-path controller: FSM encoding,
// supported oversampling ratios and frame geometry.
package uart_rx_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PRESCALE_W = 6;
  localparam int BIT_CNT_W  = 4;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  // Unsupported ratios fall back to 8 so a misconfigured frame still terminates.
  function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the RX controller (master) and the surrounding
// sampler / checker datapath (slave).
interface uart_rx_ctrl_if;
  import uart_rx_pkg::*;

  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  sampled_bit;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic                  dat_samp_en;
  logic                  strt_chk_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;

  modport master (
    input  RX_IN, Prescale, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err,
    output edge_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, P_DATA, data_valid
  );

  modport slave (
    output RX_IN, Prescale, PAR_EN, sampled_bit, strt_glitch, par_err, stp_err,
    input  edge_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, P_DATA, data_valid
  );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and bit counter; wrap marks the last edge of a bit.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  restart,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] last_edge,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  wrap
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  assign wrap     = en && (edge_cnt_q == last_edge);
  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

  // NOTE: defaults first so every path assigns both signals; no latch is inferred.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clr) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (restart) begin
      // The cycle spent in DONE already counts as edge 0 of the next start bit.
      edge_cnt_d = PRESCALE_W'(1);
      bit_cnt_d  = '0;
    end else if (en) begin
      if (wrap) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  // NOTE: non-blocking assignments for state so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: start detection FSM, checker strobes and LSB-first
// deserializer with a one-cycle data_valid on error-free frames.
module uart_rx_ctrl
  import uart_rx_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  uart_rx_ctrl_if.master rx_if
);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  err_flag_q, err_flag_d;

  logic                  cnt_clr, cnt_restart, cnt_en, wrap;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  strt_chk, par_chk, stp_chk, data_valid;

  assign cnt_en = (state_q == START) || (state_q == DATA) ||
                  (state_q == PARITY) || (state_q == STOP);

  uart_rx_edge_bit_cnt u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (cnt_clr),
    .restart   (cnt_restart),
    .en        (cnt_en),
    .last_edge (prescale_q - PRESCALE_W'(1)),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .wrap      (wrap)
  );

  always_comb begin
    state_d     = state_q;
    prescale_d  = prescale_q;
    par_en_d    = par_en_q;
    p_data_d    = p_data_q;
    err_flag_d  = err_flag_q;
    cnt_clr     = 1'b0;
    cnt_restart = 1'b0;
    strt_chk    = 1'b0;
    par_chk     = 1'b0;
    stp_chk     = 1'b0;
    data_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_if.RX_IN) begin
          state_d    = START;
          prescale_d = legal_prescale(rx_if.Prescale);
          par_en_d   = rx_if.PAR_EN;
        end
      end
      START: begin
        strt_chk = wrap;
        if (wrap) state_d = rx_if.strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        if (wrap) begin
          p_data_d = {rx_if.sampled_bit, p_data_q[DATA_WIDTH-1:1]};
          // bit_cnt counts the start bit too, so DATA_WIDTH marks the last payload bit.
          if (bit_cnt == BIT_CNT_W'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_chk = wrap;
        if (wrap) begin
          err_flag_d = err_flag_q | rx_if.par_err;
          state_d    = STOP;
        end
      end
      STOP: begin
        stp_chk = wrap;
        if (wrap) begin
          err_flag_d = err_flag_q | rx_if.stp_err;
          state_d    = DONE;
        end
      end
      DONE: begin
        data_valid = ~err_flag_q;
        err_flag_d = 1'b0;
        if (!rx_if.RX_IN) begin
          state_d     = START;
          cnt_restart = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // NOTE: P_DATA is an ordinary register, not a memory, so it is reset with the rest.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      p_data_q   <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      p_data_q   <= p_data_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign rx_if.edge_cnt    = edge_cnt;
  assign rx_if.dat_samp_en = cnt_en;
  assign rx_if.strt_chk_en = strt_chk;
  assign rx_if.par_chk_en  = par_chk;
  assign rx_if.stp_chk_en  = stp_chk;
  assign rx_if.P_DATA      = p_data_q;
  assign rx_if.data_valid  = data_valid;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: the bench plays sampler and checkers,
// aligning sampled_bit and checker results to the controller's bit windows.
module tb_uart_rx_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_rx_ctrl_if rx_if ();

  uart_rx_ctrl dut (
    .CLK   (CLK),
    .RST   (RST),
    .rx_if (rx_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Event log sampled on the falling edge, away from state updates.
  logic [7:0] dv_data_q[$];
  int         dv_cyc_q[$];
  int         strt_cnt = 0;
  int         par_cnt  = 0;
  int         stp_cnt  = 0;
  int         stp_cyc  = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (rx_if.data_valid) begin
        dv_data_q.push_back(rx_if.P_DATA);
        dv_cyc_q.push_back(cyc);
      end
      if (rx_if.strt_chk_en) strt_cnt = strt_cnt + 1;
      if (rx_if.par_chk_en) par_cnt = par_cnt + 1;
      if (rx_if.stp_chk_en) begin
        stp_cnt = stp_cnt + 1;
        stp_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed=running required=done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      rx_if.RX_IN       = 1'b1;
      rx_if.sampled_bit = 1'b1;
      rx_if.strt_glitch = 1'b1;
      rx_if.par_err     = 1'b1;
      rx_if.stp_err     = 1'b1;
    end
  endtask

  // Drive one frame. Drive j feeds the posedge j cycles after the start-edge
  // posedge; checker inputs lag RX_IN by one cycle to match the FSM's bit windows,
  // and carry noise (1 / inverted bit) outside their valid edge.
  task automatic send_frame(input logic [7:0] data, input int p, input logic [5:0] presc,
                            input bit par, input bit perr, input bit serr,
                            input bit cont, input bit next_low, input int stop_j,
                            output int t0);
    logic [10:0] fb;
    int nb, n, first, last_j, b, e;
    fb     = {1'b1, (par ? ^data : 1'b1), data, 1'b0};
    nb     = par ? 11 : 10;
    n      = nb * p;
    first  = cont ? 1 : 0;
    last_j = (stop_j < 0) ? n : stop_j;
    t0     = 0;
    for (int j = first; j <= last_j; j++) begin
      @(negedge CLK);
      if (j == first) t0 = cyc + 1 - j;
      if (j == 0) begin
        rx_if.Prescale    = presc;
        rx_if.PAR_EN      = par;
        rx_if.sampled_bit = 1'b1;
        rx_if.strt_glitch = 1'b1;
        rx_if.par_err     = 1'b1;
        rx_if.stp_err     = 1'b1;
      end else begin
        b = (j - 1) / p;
        e = (j - 1) % p;
        rx_if.sampled_bit = (e == p - 1) ? fb[b] : ~fb[b];
        rx_if.strt_glitch = (b == 0 && e == p - 1) ? 1'b0 : 1'b1;
        rx_if.par_err     = (par && b == 9 && e == p - 1) ? perr : 1'b1;
        rx_if.stp_err     = (b == nb - 1 && e == p - 1) ? serr : 1'b1;
      end
      rx_if.RX_IN = (j < n) ? fb[j / p] : !next_low;
    end
  endtask

  int base_dv, base_par, base_stp, base_strt, t0, t1;

  initial begin
    rx_if.RX_IN       = 1'b1;
    rx_if.Prescale    = 6'd8;
    rx_if.PAR_EN      = 1'b1;
    rx_if.sampled_bit = 1'b1;
    rx_if.strt_glitch = 1'b0;
    rx_if.par_err     = 1'b0;
    rx_if.stp_err     = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_edge_cnt", 32'(rx_if.edge_cnt), 0);
    check("rst_dat_samp_en", 32'(rx_if.dat_samp_en), 0);
    check("rst_strt_chk_en", 32'(rx_if.strt_chk_en), 0);
    check("rst_par_chk_en", 32'(rx_if.par_chk_en), 0);
    check("rst_stp_chk_en", 32'(rx_if.stp_chk_en), 0);
    check("rst_p_data", 32'(rx_if.P_DATA), 0);
    check("rst_data_valid", 32'(rx_if.data_valid), 0);
    RST = 1'b0;
    idle(4);

    // 1: P=8, parity, 0xA5, good frame
    base_dv = dv_data_q.size();
    send_frame(8'hA5, 8, 6'd8, 1, 0, 0, 0, 0, -1, t0);
    idle(5);
    check("t1_dv_count", 32'(dv_data_q.size() - base_dv), 1);
    if (dv_data_q.size() > base_dv) begin
      check("t1_p_data", 32'(dv_data_q[base_dv]), 32'hA5);
      check("t1_latency", 32'(dv_cyc_q[base_dv] - t0), 88);
    end
    check("t1_idle_samp_en", 32'(rx_if.dat_samp_en), 0);

    // 2: start glitch aborts the frame
    base_dv = dv_data_q.size(); base_par = par_cnt; base_stp = stp_cnt; base_strt = strt_cnt;
    for (int j = 0; j < 12; j++) begin
      @(negedge CLK);
      rx_if.Prescale    = 6'd8;
      rx_if.RX_IN       = (j < 3) ? 1'b0 : 1'b1;
      rx_if.strt_glitch = (j - 1 == 7) ? 1'b1 : 1'b0;
      rx_if.sampled_bit = 1'b1;
      rx_if.par_err     = 1'b1;
      rx_if.stp_err     = 1'b1;
    end
    idle(96);
    check("t2_strt_chk", 32'(strt_cnt - base_strt), 1);
    check("t2_no_par_chk", 32'(par_cnt - base_par), 0);
    check("t2_no_stp_chk", 32'(stp_cnt - base_stp), 0);
    check("t2_no_dv", 32'(dv_data_q.size() - base_dv), 0);
    check("t2_idle_samp_en", 32'(rx_if.dat_samp_en), 0);

    // 3: P=16, parity error on 0x3C, then good 0x81
    base_dv = dv_data_q.size(); base_par = par_cnt;
    send_frame(8'h3C, 16, 6'd16, 1, 1, 0, 0, 0, -1, t0);
    idle(5);
    check("t3_err_no_dv", 32'(dv_data_q.size() - base_dv), 0);
    check("t3_p_data_kept", 32'(rx_if.P_DATA), 32'h3C);
    check("t3_par_chk", 32'(par_cnt - base_par), 1);
    send_frame(8'h81, 16, 6'd16, 1, 0, 0, 0, 0, -1, t0);
    idle(5);
    check("t3_good_dv", 32'(dv_data_q.size() - base_dv), 1);
    if (dv_data_q.size() > base_dv) begin
      check("t3_good_data", 32'(dv_data_q[base_dv]), 32'h81);
      check("t3_good_latency", 32'(dv_cyc_q[base_dv] - t0), 176);
    end

    // 4: P=32, no parity, stop error on 0x0F
    base_dv = dv_data_q.size(); base_par = par_cnt; base_stp = stp_cnt;
    send_frame(8'h0F, 32, 6'd32, 0, 0, 1, 0, 0, -1, t0);
    idle(5);
    check("t4_no_par_chk", 32'(par_cnt - base_par), 0);
    check("t4_no_dv", 32'(dv_data_q.size() - base_dv), 0);
    check("t4_stp_chk", 32'(stp_cnt - base_stp), 1);
    check("t4_stp_cycle", 32'(stp_cyc - t0), 32 * 9 + 31);
    check("t4_p_data", 32'(rx_if.P_DATA), 32'h0F);

    // 5: back-to-back 0x55 / 0xAA at P=8
    base_dv = dv_data_q.size();
    send_frame(8'h55, 8, 6'd8, 1, 0, 0, 0, 1, -1, t0);
    send_frame(8'hAA, 8, 6'd8, 1, 0, 0, 1, 0, -1, t1);
    idle(5);
    check("t5_dv_count", 32'(dv_data_q.size() - base_dv), 2);
    if (dv_data_q.size() >= base_dv + 2) begin
      check("t5_data0", 32'(dv_data_q[base_dv]), 32'h55);
      check("t5_data1", 32'(dv_data_q[base_dv + 1]), 32'hAA);
      check("t5_spacing", 32'(dv_cyc_q[base_dv + 1] - dv_cyc_q[base_dv]), 88);
      check("t5_latency1", 32'(dv_cyc_q[base_dv] - t0), 88);
    end

    // Unsupported Prescale (12) behaves as 8
    base_dv = dv_data_q.size();
    send_frame(8'h6B, 8, 6'd12, 1, 0, 0, 0, 0, -1, t0);
    idle(5);
    check("bad_presc_dv", 32'(dv_data_q.size() - base_dv), 1);
    if (dv_data_q.size() > base_dv) begin
      check("bad_presc_data", 32'(dv_data_q[base_dv]), 32'h6B);
      check("bad_presc_latency", 32'(dv_cyc_q[base_dv] - t0), 88);
    end

    // 6: async reset during DATA bit 4, Prescale changed mid-frame
    base_dv = dv_data_q.size();
    send_frame(8'h96, 8, 6'd8, 1, 0, 0, 0, 0, 44, t0);
    @(negedge CLK);
    rx_if.Prescale = 6'd16;
    @(negedge CLK);
    check("t6_midframe_samp_en", 32'(rx_if.dat_samp_en), 1);
    #2 RST = 1'b1;
    #1;
    check("t6_rst_edge_cnt", 32'(rx_if.edge_cnt), 0);
    check("t6_rst_samp_en", 32'(rx_if.dat_samp_en), 0);
    check("t6_rst_p_data", 32'(rx_if.P_DATA), 0);
    check("t6_rst_strobes", 32'({rx_if.strt_chk_en, rx_if.par_chk_en, rx_if.stp_chk_en, rx_if.data_valid}), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    idle(3);
    check("t6_no_dv_after_abort", 32'(dv_data_q.size() - base_dv), 0);
    send_frame(8'hC3, 16, 6'd16, 1, 0, 0, 0, 0, -1, t0);
    idle(5);
    check("t6_dv_count", 32'(dv_data_q.size() - base_dv), 1);
    if (dv_data_q.size() > base_dv) begin
      check("t6_data", 32'(dv_data_q[base_dv]), 32'hC3);
      check("t6_latency", 32'(dv_cyc_q[base_dv] - t0), 176);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
